// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory control lines seen by dm_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dm_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_len;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_ack;
    logic        c_err;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_len;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        dm_MemWrite;
    logic        dm_MemRead;
    logic [2:0]  dm_length;
    logic [31:0] dm_Addr;
    logic [31:0] dm_Writedata;
    logic [31:0] dm_Readdata;

    logic        busy;

    modport slave (
        input  c_req, c_we, c_len, c_addr, c_wdata,
        output c_ack, c_err, c_rdata,
        input  d_req, d_we, d_len, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        output dm_MemWrite, dm_MemRead, dm_length, dm_Addr, dm_Writedata,
        input  dm_Readdata,
        output busy
    );

    modport master (
        output c_req, c_we, c_len, c_addr, c_wdata,
        input  c_ack, c_err, c_rdata,
        output d_req, d_we, d_len, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        input  dm_MemWrite, dm_MemRead, dm_length, dm_Addr, dm_Writedata,
        output dm_Readdata,
        input  busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port (CPU / DMA) arbiter for the single-port data memory: IDLE/ACCESS/DONE sequencing,
// length/alignment/range checking at grant, and a one-cycle ack per completed request.
module dm_arbiter #(
    parameter int DM_BYTES   = 128,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg;
    logic        owner_reg;       // 0 = CPU, 1 = DMA
    logic        last_grant_reg;  // 0 = CPU, 1 = DMA

    logic        sel_dma;
    logic        sel_we;
    logic [2:0]  sel_len;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [32:0] size;
    logic [32:0] end_addr;
    logic        fault;

    // Winner selection and fault screening for the request that would be granted this edge.
    always_comb begin
        sel_dma   = bus.d_req && (!bus.c_req || (!FIXED_PRIO && !last_grant_reg));
        sel_we    = sel_dma ? bus.d_we    : bus.c_we;
        sel_len   = sel_dma ? bus.d_len   : bus.c_len;
        sel_addr  = sel_dma ? bus.d_addr  : bus.c_addr;
        sel_wdata = sel_dma ? bus.d_wdata : bus.c_wdata;
        case (sel_len[1:0])
            2'b00:   size = 33'd4;
            2'b01:   size = 33'd2;
            default: size = 33'd1;
        endcase
        end_addr = {1'b0, sel_addr} + size;
        fault = 1'b0;
        if (sel_len == 3'b011 || sel_len == 3'b100 || sel_len == 3'b111)
            fault = 1'b1;
        if (sel_we && sel_len[2])
            fault = 1'b1;
        if (sel_len[1:0] == 2'b00 && sel_addr[1:0] != 2'b00)
            fault = 1'b1;
        if (sel_len[1:0] == 2'b01 && sel_addr[0])
            fault = 1'b1;
        if (end_addr > 33'(DM_BYTES))
            fault = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            owner_reg        <= 1'b0;
            last_grant_reg   <= 1'b1;
            bus.c_ack        <= 1'b0;
            bus.c_err        <= 1'b0;
            bus.c_rdata      <= 32'd0;
            bus.d_ack        <= 1'b0;
            bus.d_err        <= 1'b0;
            bus.d_rdata      <= 32'd0;
            bus.dm_MemWrite  <= 1'b0;
            bus.dm_MemRead   <= 1'b0;
            bus.dm_length    <= 3'd0;
            bus.dm_Addr      <= 32'd0;
            bus.dm_Writedata <= 32'd0;
        end else begin
            bus.c_ack <= 1'b0;
            bus.c_err <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.d_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.c_req || bus.d_req) begin
                        owner_reg      <= sel_dma;
                        last_grant_reg <= sel_dma;
                        if (fault) begin
                            // Rejected requests go straight to DONE; the memory is never driven.
                            state_reg <= DONE;
                            if (sel_dma) begin
                                bus.d_ack <= 1'b1;
                                bus.d_err <= 1'b1;
                            end else begin
                                bus.c_ack <= 1'b1;
                                bus.c_err <= 1'b1;
                            end
                        end else begin
                            state_reg        <= ACCESS;
                            bus.dm_Addr      <= sel_addr;
                            bus.dm_length    <= sel_len;
                            bus.dm_Writedata <= sel_wdata;
                            bus.dm_MemWrite  <= sel_we;
                            bus.dm_MemRead   <= !sel_we;
                        end
                    end
                end
                ACCESS: begin
                    state_reg       <= DONE;
                    bus.dm_MemWrite <= 1'b0;
                    bus.dm_MemRead  <= 1'b0;
                    // dm_MemWrite still reflects this access's direction at the closing edge.
                    if (owner_reg) begin
                        bus.d_ack   <= 1'b1;
                        bus.d_rdata <= bus.dm_MemWrite ? 32'd0 : bus.dm_Readdata;
                    end else begin
                        bus.c_ack   <= 1'b1;
                        bus.c_rdata <= bus.dm_MemWrite ? 32'd0 : bus.dm_Readdata;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
endmodule
